// File: rtl/bcd_display_pkg.sv
// Shared segment constants and the nibble-to-segment mapping for the two-digit scanner.
// All segment patterns are active-low {g,f,e,d,c,b,a}.
package bcd_display_pkg;

   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   localparam logic [1:0] AN_OFF   = 2'b11;
   localparam logic [1:0] AN_ONES  = 2'b10;
   localparam logic [1:0] AN_TENS  = 2'b01;

   // Non-BCD nibbles render as a dash so corrupted counts are visible.
   function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
      logic [6:0] seg;
      seg = SEG_DASH;
      case (nibble)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder.
module bcd_to_seg7
   import bcd_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = seg_decode(nibble);
   end

endmodule

// File: rtl/bcd_display_scan.sv
// Two-digit multiplexed 7-segment driver with a frame-synchronous shadow latch,
// so a count change never shows half-old / half-new digits within one scan.
module bcd_display_scan
   import bcd_display_pkg::*;
#(
   parameter int SCAN_DIV      = 4,
   parameter bit BLANK_LEADING = 1'b1
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] count,
   input  logic       en,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       frame
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
   logic             sel_reg, sel_next;
   logic [7:0]       shadow_reg, shadow_next;
   logic             slot_last;
   logic [3:0]       nibble;
   logic [6:0]       digit_seg;
   logic             tens_blank;

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_reg <= '0;
         sel_reg     <= 1'b0;
         shadow_reg  <= 8'h00;
      end else begin
         div_cnt_reg <= div_cnt_next;
         sel_reg     <= sel_next;
         shadow_reg  <= shadow_next;
      end
   end

   always_comb begin
      slot_last    = (div_cnt_reg == DIV_LAST);
      frame        = slot_last & sel_reg;
      div_cnt_next = slot_last ? '0 : div_cnt_reg + 1'b1;
      sel_next     = slot_last ? ~sel_reg : sel_reg;
      shadow_next  = frame ? count : shadow_reg;
   end

   // Single decoder shared by both slots; the nibble mux follows sel.
   assign nibble = sel_reg ? shadow_reg[7:4] : shadow_reg[3:0];

   bcd_to_seg7 u_dec (
      .nibble (nibble),
      .seg    (digit_seg)
   );

   always_comb begin
      tens_blank = BLANK_LEADING && sel_reg && (shadow_reg[7:4] == 4'd0);
      an         = AN_OFF;
      seg        = SEG_OFF;
      if (en && !tens_blank) begin
         an  = sel_reg ? AN_TENS : AN_ONES;
         seg = digit_seg;
      end
   end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench: per-cycle directed expectations are queued by the stimulus
// process and compared by a negedge monitor against two DUTs (blanking on/off).
module tb_bcd_display_scan;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                          S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                          S9 = 7'b0010000, SD = 7'b0111111, SOFF = 7'h7F;
   localparam logic [1:0] AT = 2'b01, AOFF = 2'b11;

   typedef struct packed {
      logic [1:0] an;
      logic [6:0] seg;
      logic       frame;
      logic [1:0] nan;
      logic [6:0] nseg;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] count = 8'h42;
   logic       en = 1'b1;
   logic [6:0] seg, seg_nb;
   logic [1:0] an, an_nb;
   logic       frame, frame_nb;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   always #5 clk = ~clk;

   bcd_display_scan #(.SCAN_DIV(4), .BLANK_LEADING(1'b1)) dut (
      .clk(clk), .reset(reset), .count(count), .en(en),
      .seg(seg), .an(an), .frame(frame)
   );

   bcd_display_scan #(.SCAN_DIV(4), .BLANK_LEADING(1'b0)) dut_nb (
      .clk(clk), .reset(reset), .count(count), .en(en),
      .seg(seg_nb), .an(an_nb), .frame(frame_nb)
   );

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t x;
         x = q.pop_front();
         chk("an", {5'd0, an}, {5'd0, x.an});
         chk("seg", seg, x.seg);
         chk("frame", {6'd0, frame}, {6'd0, x.frame});
         chk("an_nb", {5'd0, an_nb}, {5'd0, x.nan});
         chk("seg_nb", seg_nb, x.nseg);
         chk("frame_nb", {6'd0, frame_nb}, {6'd0, x.frame});
         $display("cycle=%0d count=%h en=%b reset=%b an=%b seg=%b frame=%b an_nb=%b seg_nb=%b",
                  cyc, count, en, reset, an, seg, frame, an_nb, seg_nb);
         cyc++;
      end
   end

   // One 8-cycle scan starting at the ones slot. count switches from ca to cb at cycle sw;
   // reset is asserted during cycle rst_at, after which the scan restarts at phase 0.
   task automatic frame8(input logic [7:0] ca, input logic [7:0] cb, input int sw,
                         input logic e, input logic [6:0] os,
                         input logic [1:0] tan, input logic [6:0] ts,
                         input logic [1:0] ntan, input logic [6:0] nts,
                         input int rst_at);
      for (int c = 0; c < 8; c++) begin
         exp_t x;
         count = (c < sw) ? ca : cb;
         en    = e;
         reset = (c == rst_at);
         if (c < 4) begin
            x.an = 2'b10; x.seg = os;  x.nan = 2'b10; x.nseg = os;
         end else begin
            x.an = tan;   x.seg = ts;  x.nan = ntan;  x.nseg = nts;
         end
         if (!e) begin
            x.an = AOFF; x.seg = SOFF; x.nan = AOFF; x.nseg = SOFF;
         end
         x.frame = (c == 7);
         q.push_back(x);
         @(posedge clk);
         #1;
         if (c == rst_at) break;
      end
      reset = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      // Reset held two cycles with a nonzero count present.
      frame8(8'h42, 8'h42, 8, 1'b1, S0, AOFF, SOFF, AT, S0, 0);
      frame8(8'h42, 8'h42, 8, 1'b1, S0, AOFF, SOFF, AT, S0, 0);
      // Shadow still 00 after reset: tens blanked only on the blanking DUT.
      frame8(8'h57, 8'h57, 8, 1'b1, S0, AOFF, SOFF, AT, S0, -1);
      frame8(8'h05, 8'h05, 8, 1'b1, S7, AT, S5, AT, S5, -1);
      frame8(8'h3C, 8'h3C, 8, 1'b1, S5, AOFF, SOFF, AT, S0, -1);
      frame8(8'h12, 8'h12, 8, 1'b1, SD, AT, S3, AT, S3, -1);
      // Count changes mid ones slot; display holds 1/2 until the frame edge.
      frame8(8'h12, 8'h98, 2, 1'b1, S2, AT, S1, AT, S1, -1);
      // Reset coincident with frame: 98 must not be captured.
      frame8(8'h98, 8'h98, 8, 1'b1, S8, AT, S9, AT, S9, 7);
      frame8(8'h21, 8'h21, 8, 1'b0, S0, AOFF, SOFF, AT, S0, -1);
      frame8(8'h21, 8'h21, 8, 1'b0, S0, AOFF, SOFF, AT, S0, -1);
      // Re-enabled with no phase slip, then reset in the tens slot.
      frame8(8'h64, 8'h64, 8, 1'b1, S1, AT, S2, AT, S2, 5);
      frame8(8'h64, 8'h64, 8, 1'b1, S0, AOFF, SOFF, AT, S0, -1);
      frame8(8'h64, 8'h64, 8, 1'b1, S4, AT, S6, AT, S6, -1);
      for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d want=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout cycle=%0d want=finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
